lsu_split: RTL and testbench

- Load/store initiator between the core's memory stage and a word-wide, byte-enabled data memory port.
- Accepts one byte, halfword or word access per transaction, including unaligned ones.
- Splits a word-crossing access into two aligned beats, then merges and extends the read data.
- Holds at most one access in flight; the core stalls on req_ready.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_split.sv | 147 ++++++++++++++
 tb/tb_lsu_split.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store split unit.
//   SZ_BYTE / SZ_HALF / SZ_WORD : req_size encodings (2'b11 is handled as word)
//   lsu_state_t                 : controller state encoding
//   size_mask()                 : unshifted byte-enable pattern for an access size
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT1 = 3'd1,
        WAIT1 = 3'd2,
        BEAT2 = 3'd3,
        WAIT2 = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for lsu_split.
//   size_i, signed_i : access size and load sign-extension select
//   sh_i             : byte offset of the access inside its word
//   wdata_i          : LSB-justified store data
//   lo_i, hi_i       : first / second read beat (hi_i is 0 for one-beat loads)
//   mask_o           : 8-bit byte enable across two words; [7:4] nonzero => split
//   wide_o           : store data shifted into lane position across two words
//   rdata_o          : loaded value, realigned and sign/zero extended
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  sh_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  mask_o,
    output logic [63:0] wide_o,
    output logic [31:0] rdata_o
);

    logic [31:0] x;

    always_comb begin
        mask_o = {4'b0000, size_mask(size_i)} << sh_i;
        wide_o = {32'h0, wdata_i} << {sh_i, 3'b000};

        // Only the low word of the realigned pair can hold the accessed bytes.
        x = 32'({hi_i, lo_i} >> {sh_i, 3'b000});

        case (size_i)
            SZ_BYTE: rdata_o = signed_i ? {{24{x[7]}}, x[7:0]}   : {24'h0, x[7:0]};
            SZ_HALF: rdata_o = signed_i ? {{16{x[15]}}, x[15:0]} : {16'h0, x[15:0]};
            default: rdata_o = x;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// lsu_split: load/store initiator between the core memory stage and a
// word-wide byte-enabled data memory port. Unaligned accesses that cross a
// word boundary are issued as two aligned beats and the read data is merged.
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready               : core request handshake
//   req_we/size/signed/addr/wdata     : core request fields
//   resp_valid/resp_rdata             : completion pulse and extended load data
//   mem_req/mem_gnt                   : memory beat handshake
//   mem_we/addr/be/wdata              : memory beat fields
//   mem_rvalid/mem_rdata              : in-order beat completion
//
// state | meaning
// IDLE  | ready for a new request
// BEAT1 | first (or only) beat requested, waiting for gnt
// WAIT1 | first beat granted, waiting for rvalid
// BEAT2 | second beat requested, waiting for gnt
// WAIT2 | second beat granted, waiting for rvalid
// RESP  | merge/extend read data; completion pulse follows
module lsu_split
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int WA_W = ADDR_W - 2;

    lsu_state_t        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;

    logic [7:0]        mask;
    logic [63:0]       wide;
    logic [31:0]       ext_rdata;
    logic              two_beat;
    logic [WA_W-1:0]   word_q;

    lsu_lane_align u_align (
        .size_i   (size_q),
        .signed_i (signed_q),
        .sh_i     (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .lo_i     (lo_q),
        .hi_i     (hi_q),
        .mask_o   (mask),
        .wide_o   (wide),
        .rdata_o  (ext_rdata)
    );

    assign two_beat = |mask[7:4];
    assign word_q   = addr_q[ADDR_W-1:2];

    assign req_ready  = (state_q == IDLE);
    assign mem_req    = (state_q == BEAT1) || (state_q == BEAT2);
    assign mem_we     = we_q;
    // Second-beat word address wraps naturally at the top of the word space.
    assign mem_addr   = (state_q == BEAT2) ? word_q + WA_W'(1) : word_q;
    assign mem_be     = (state_q == BEAT2) ? mask[7:4]   : mask[3:0];
    assign mem_wdata  = (state_q == BEAT2) ? wide[63:32] : wide[31:0];
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            hi_q         <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        // hi must read as zero when only one beat is issued
                        lo_q     <= 32'h0;
                        hi_q     <= 32'h0;
                        state_q  <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (mem_gnt) state_q <= WAIT1;
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        lo_q    <= mem_rdata;
                        state_q <= two_beat ? BEAT2 : RESP;
                    end
                end
                BEAT2: begin
                    if (mem_gnt) state_q <= WAIT2;
                end
                WAIT2: begin
                    if (mem_rvalid) begin
                        hi_q    <= mem_rdata;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Extension works from the registered beats, keeping
                    // mem_rdata off the shift/extend path.
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? 32'h0 : ext_rdata;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split.sv
module tb_lsu_split;

    localparam int ADDR_W = 13;
    localparam int AW     = ADDR_W - 2;

    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    lsu_split #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: gnt is a level from the bench, rvalid follows one cycle
    // after gnt unless held back. Every granted beat is logged.
    logic        gnt_en;
    logic        hold_rv;
    logic        pend = 1'b0;
    logic [31:0] pend_data = 32'h0;
    logic [31:0] mem [0:(1<<AW)-1];

    int          nbeats = 0;
    logic [AW-1:0] b_addr [0:63];
    logic [3:0]    b_be   [0:63];
    logic [31:0]   b_wd   [0:63];
    logic          b_we   [0:63];

    assign mem_gnt    = gnt_en;
    assign mem_rvalid = pend && !hold_rv;
    assign mem_rdata  = pend_data;

    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            pend      <= 1'b1;
            pend_data <= mem[mem_addr];
            b_addr[nbeats[5:0]] <= mem_addr;
            b_be[nbeats[5:0]]   <= mem_be;
            b_wd[nbeats[5:0]]   <= mem_wdata;
            b_we[nbeats[5:0]]   <= mem_we;
            nbeats    <= nbeats + 1;
        end else if (mem_rvalid) begin
            pend <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // lat counts cycles from the accept cycle (0); returns in the resp cycle.
    task automatic wait_resp(input int lat0, output logic [31:0] rd, output int lat);
        lat = lat0;
        while (!resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("resp_seen", {31'h0, resp_valid}, 32'h1);
        rd = resp_rdata;
    endtask

    task automatic xfer(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output int b0);
        b0 = nbeats;
        issue(we, size, sgn, addr, wdata);
        wait_resp(1, rd, lat);
    endtask

    logic [31:0] rd;
    int          lat;
    int          b0;
    int          seen;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'h0;
        gnt_en     = 1'b1;
        hold_rv    = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[1]     = 32'hAB000000;
        mem[2]     = 32'h000000FF;
        mem[0]     = 32'h00800000;
        mem[8]     = 32'h12345678;
        mem[11'h7FF] = 32'hBEEF0000;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);

        // aligned word store
        xfer(1'b1, SZW, 1'b0, 13'h010, 32'hDEADBEEF, rd, lat, b0);
        chk("stw_beats", 32'(nbeats - b0), 32'd1);
        chk("stw_addr", 32'(b_addr[b0]), 32'h004);
        chk("stw_be", 32'(b_be[b0]), 32'hF);
        chk("stw_wdata", b_wd[b0], 32'hDEADBEEF);
        chk("stw_we", {31'h0, b_we[b0]}, 32'h1);
        chk("stw_lat", 32'(lat), 32'd4);
        chk("stw_rdata", rd, 32'h0);

        // unaligned word store split across words 4 and 5
        @(posedge clk); #1;
        xfer(1'b1, SZW, 1'b0, 13'h013, 32'h11223344, rd, lat, b0);
        chk("stu_beats", 32'(nbeats - b0), 32'd2);
        chk("stu_addr1", 32'(b_addr[b0]), 32'h004);
        chk("stu_be1", 32'(b_be[b0]), 32'h8);
        chk("stu_wd1", b_wd[b0], 32'h44000000);
        chk("stu_addr2", 32'(b_addr[b0+1]), 32'h005);
        chk("stu_be2", 32'(b_be[b0+1]), 32'h7);
        chk("stu_wd2", b_wd[b0+1], 32'h00112233);
        chk("stu_lat", 32'(lat), 32'd6);
        chk("stu_rdata", rd, 32'h0);

        // split halfword load, signed then unsigned
        @(posedge clk); #1;
        xfer(1'b0, SZH, 1'b1, 13'h007, 32'h0, rd, lat, b0);
        chk("lhs_be1", 32'(b_be[b0]), 32'h8);
        chk("lhs_be2", 32'(b_be[b0+1]), 32'h1);
        chk("lhs_addr2", 32'(b_addr[b0+1]), 32'h002);
        chk("lhs_rdata", rd, 32'hFFFFFFAB);
        chk("lhs_lat", 32'(lat), 32'd6);
        @(posedge clk); #1;
        xfer(1'b0, SZH, 1'b0, 13'h007, 32'h0, rd, lat, b0);
        chk("lhu_rdata", rd, 32'h0000FFAB);

        // byte loads from lane 2
        @(posedge clk); #1;
        xfer(1'b0, SZB, 1'b1, 13'h002, 32'h0, rd, lat, b0);
        chk("lbs_beats", 32'(nbeats - b0), 32'd1);
        chk("lbs_be", 32'(b_be[b0]), 32'h4);
        chk("lbs_rdata", rd, 32'hFFFFFF80);
        @(posedge clk); #1;
        xfer(1'b0, SZB, 1'b0, 13'h002, 32'h0, rd, lat, b0);
        chk("lbu_rdata", rd, 32'h00000080);

        // word load wrapping from the top word to word 0
        mem[0] = 32'h0000CAFE;
        @(posedge clk); #1;
        xfer(1'b0, SZW, 1'b0, 13'h1FFE, 32'h0, rd, lat, b0);
        chk("wrap_addr1", 32'(b_addr[b0]), 32'h7FF);
        chk("wrap_be1", 32'(b_be[b0]), 32'hC);
        chk("wrap_addr2", 32'(b_addr[b0+1]), 32'h000);
        chk("wrap_be2", 32'(b_be[b0+1]), 32'h3);
        chk("wrap_rdata", rd, 32'hCAFEBEEF);

        // grant withheld for three BEAT1 cycles
        @(posedge clk); #1;
        gnt_en = 1'b0;
        b0 = nbeats;
        issue(1'b1, SZH, 1'b0, 13'h005, 32'h0000A5C3);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", {31'h0, mem_req}, 32'h1);
            chk("stall_addr", 32'(mem_addr), 32'h001);
            chk("stall_be", 32'(mem_be), 32'h6);
            chk("stall_wdata", mem_wdata, 32'h00A5C300);
            chk("stall_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        gnt_en = 1'b1;
        wait_resp(4, rd, lat);
        chk("stall_beats", 32'(nbeats - b0), 32'd1);
        chk("stall_lat", 32'(lat), 32'd7);

        // reset while waiting for the first beat's rvalid
        @(posedge clk); #1;
        hold_rv = 1'b1;
        issue(1'b0, SZW, 1'b0, 13'h020, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        hold_rv = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rst_mid_no_resp", 32'(seen), 32'd0);
        chk("rst_mid_rdata", resp_rdata, 32'h0);
        chk("rst_mid_idle", {31'h0, req_ready}, 32'h1);

        // recovery, then a back-to-back request in the following IDLE cycle
        xfer(1'b0, SZW, 1'b0, 13'h020, 32'h0, rd, lat, b0);
        chk("rec_rdata", rd, 32'h12345678);
        chk("rec_lat", 32'(lat), 32'd4);
        chk("b2b_ready", {31'h0, req_ready}, 32'h1);
        issue(1'b0, SZB, 1'b0, 13'h021, 32'h0);
        chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
        chk("resp_hold", resp_rdata, 32'h12345678);
        wait_resp(1, rd, lat);
        chk("b2b_rdata", rd, 32'h00000056);
        chk("b2b_lat", 32'(lat), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
